queen_solver: RTL and testbench
===============================

Name: queen_solver

Overview:
- Parametrised N-queens backtracking engine with a proper start/busy/done handshake.
- Either counts all solutions or stops at the first one; each solution is streamed out through a valid/ready port.
- Used as a self-checking compute workload and as a source of board patterns for downstream blocks in the puzzle-engine family.

Parameters:
- N, 8: board size (rows = columns = N); legal range 1..16.
- LN, 5: width of a row/column index; must satisfy 2**LN > N.
- CW, 32: width of the solution counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a search; sampled only in IDLE.
- mode  input  1  0 = count all solutions, 1 = stop after first solution; sampled with start.
- abort  input  1  terminates a running search.
- busy  output  1  high from the cycle after an accepted start until DONE/IDLE.
- done  output  1  one-cycle pulse when a search completes normally.
- found  output  1  at least one solution was found in the last search; valid when done pulses.
- count  output  CW  solutions found in the current/last search.
- sat  output  1  count saturated.
- sol_valid  output  1  solution available on sol_cols.
- sol_ready  input  1  consumer accepts solution; tie high if the stream is unused.
- sol_cols  output  N*LN  column of the queen in row r at bits [r*LN +: LN].

Behaviour:
- Reset (async): state = IDLE; busy, done, found, sat, sol_valid = 0; count = 0; sol_cols = 0; all internal occupancy masks (columns N bits, both diagonals 2N-1 bits) cleared.
- States: IDLE, SEARCH, EMIT, DONE.
- IDLE:
  - start=1 -> SEARCH; clear masks, count, sat and found; latch mode; row k = 0, candidate column 0.
  - start while busy is ignored.
- SEARCH, one candidate test per cycle:
  - Candidate c is legal in row k if column c, diagonal k+c and anti-diagonal k-c+N-1 are all free.
  - Legal: place the queen (set the three marks, record c for row k).
    - If k = N-1 -> EMIT.
    - Otherwise k+1, candidate 0.
  - Illegal: c+1.
  - c reaching N: backtrack to k-1, unmark that row's queen, continue from its column+1.
  - Backtracking out of row 0 -> DONE.
  - Solutions are enumerated in lexicographic order of (row0 col, row1 col, ...).
- Entering EMIT:
  - count increments, saturating at 2**CW-1; sat sets when the increment would wrap.
  - found <= 1; sol_valid <= 1; sol_cols holds the placement.
- EMIT:
  - sol_cols and sol_valid stay stable while sol_ready=0; the search stalls.
  - On sol_valid && sol_ready: sol_valid drops next cycle.
    - mode=0: return to SEARCH, undoing the last-row queen and continuing with its next column.
    - mode=1: -> DONE.
- DONE: done=1 for exactly one cycle, busy=0 -> IDLE. count, found, sat and sol_cols hold until the next accepted start.
- abort (SEARCH or EMIT):
  - Next cycle state = IDLE; busy=0; sol_valid=0; no done pulse.
  - count, found and sat keep their partial values.
  - abort has priority over a simultaneous sol_ready handshake; that solution is counted but is not considered delivered.
- abort in IDLE or DONE: no effect.
- Reset mid-search: immediate return to the reset state; no output pulses.
- N=1: single solution (0), count=1, found=1.
- N=2 or N=3: count=0, found=0; done still pulses.
- Search must finish in bounded time; no cycle-count guarantee beyond one candidate per SEARCH cycle.

Test Plan:
- N=8, mode=0, sol_ready=1, pulse start -> exactly 92 sol_valid handshakes; done pulses once; count=92, found=1, sat=0. First sol_cols rows = 0,4,7,5,2,6,1,3.
- N=4, mode=0, sol_ready toggled randomly -> solutions (1,3,0,2) then (2,0,3,1), each held stable while stalled; count=2.
- N=6, mode=1 -> one handshake with (1,3,5,0,2,4); done pulses; count=1; no further sol_valid.
- N=3 and N=1 -> count=0 with found=0, and count=1 with sol_cols=0, respectively; done pulses in both.
- N=8, CW=3, mode=0 -> count sticks at 7, sat=1 after the 8th solution; all 92 solutions still streamed.
- N=8: abort 50 cycles after start -> busy low next cycle, no done pulse, count unchanged afterwards. A start during busy is ignored. Assert rst mid-EMIT -> all outputs 0 immediately; a restart then yields 92.

Source files
------------

// File: rtl/queen_solver_if.sv
// Control handshake and solution stream bundle for queen_solver.
// The master drives the requests and the slave drives the results.
interface queen_solver_if #(
  parameter int N  = 8,
  parameter int LN = 5,
  parameter int CW = 32
) ();
  logic            start;
  logic            mode;
  logic            abort;
  logic            busy;
  logic            done;
  logic            found;
  logic [CW-1:0]   count;
  logic            sat;
  logic            sol_valid;
  logic            sol_ready;
  logic [N*LN-1:0] sol_cols;

  modport master (
    output start, mode, abort, sol_ready,
    input  busy, done, found, count, sat, sol_valid, sol_cols
  );

  modport slave (
    input  start, mode, abort, sol_ready,
    output busy, done, found, count, sat, sol_valid, sol_cols
  );
endinterface

// File: rtl/queen_solver.sv
// N-queens backtracking engine: tests one candidate per cycle and streams
// each solution found over a valid/ready port.
module queen_solver #(
  parameter int N  = 8,
  parameter int LN = 5,
  parameter int CW = 32
) (
  input logic           clk,
  input logic           rst,
  queen_solver_if.slave bus
);
  localparam int DW = 2 * N - 1;
  localparam int SW = N * LN;

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_EMIT, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [LN-1:0] row_q, row_d;
  logic [LN-1:0] cand_q, cand_d;
  logic [SW-1:0] place_q, place_d;
  logic [SW-1:0] sol_q, sol_d;
  logic [N-1:0]  colm_q, colm_d;
  logic [DW-1:0] dgm_q, dgm_d;
  logic [DW-1:0] adm_q, adm_d;
  logic          mode_q, mode_d;
  logic          found_q, found_d;
  logic          sat_q, sat_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [N-1:0] col_bit(input logic [LN-1:0] c);
    return N'(1) << c;
  endfunction

  function automatic logic [DW-1:0] dg_bit(input logic [LN-1:0] r, input logic [LN-1:0] c);
    return DW'(1) << (32'(r) + 32'(c));
  endfunction

  function automatic logic [DW-1:0] ad_bit(input logic [LN-1:0] r, input logic [LN-1:0] c);
    return DW'(1) << (32'(r) + 32'(N - 1) - 32'(c));
  endfunction

  logic [LN-1:0] row_m1, prev_col, last_col, un_row, un_col;
  logic [N-1:0]  pc_bit, uc_bit;
  logic [DW-1:0] pd_bit, pa_bit, ud_bit, ua_bit;
  logic [SW-1:0] slot_mask, slot_val;
  logic          legal, cand_end, last_row;

  assign row_m1   = row_q - LN'(1);
  assign prev_col = LN'(place_q >> (LN * 32'(row_m1)));
  assign last_col = LN'(place_q >> (LN * 32'(row_q)));

  // Undo targets the previous row when backtracking, the last row after an emit.
  assign un_row = (state_q == S_EMIT) ? row_q : row_m1;
  assign un_col = (state_q == S_EMIT) ? last_col : prev_col;

  assign pc_bit = col_bit(cand_q);
  assign pd_bit = dg_bit(row_q, cand_q);
  assign pa_bit = ad_bit(row_q, cand_q);
  assign uc_bit = col_bit(un_col);
  assign ud_bit = dg_bit(un_row, un_col);
  assign ua_bit = ad_bit(un_row, un_col);

  assign cand_end  = (cand_q == LN'(N));
  assign last_row  = (row_q == LN'(N - 1));
  assign legal     = ((colm_q & pc_bit) == '0) && ((dgm_q & pd_bit) == '0) &&
                     ((adm_q & pa_bit) == '0);
  assign slot_mask = SW'({LN{1'b1}}) << (LN * 32'(row_q));
  assign slot_val  = SW'(cand_q) << (LN * 32'(row_q));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cand_d  = cand_q;
    place_d = place_q;
    sol_d   = sol_q;
    colm_d  = colm_q;
    dgm_d   = dgm_q;
    adm_d   = adm_q;
    mode_d  = mode_q;
    found_d = found_q;
    sat_d   = sat_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SEARCH;
          row_d   = '0;
          cand_d  = '0;
          colm_d  = '0;
          dgm_d   = '0;
          adm_d   = '0;
          count_d = '0;
          sat_d   = 1'b0;
          found_d = 1'b0;
          mode_d  = bus.mode;
        end
      end
      S_SEARCH: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (cand_end) begin
          if (row_q == '0) begin
            state_d = S_DONE;
          end else begin
            row_d  = row_m1;
            cand_d = prev_col + LN'(1);
            colm_d = colm_q & ~uc_bit;
            dgm_d  = dgm_q & ~ud_bit;
            adm_d  = adm_q & ~ua_bit;
          end
        end else if (legal) begin
          colm_d  = colm_q | pc_bit;
          dgm_d   = dgm_q | pd_bit;
          adm_d   = adm_q | pa_bit;
          place_d = (place_q & ~slot_mask) | slot_val;
          if (last_row) begin
            state_d = S_EMIT;
            sol_d   = (place_q & ~slot_mask) | slot_val;
            found_d = 1'b1;
            if (count_q == '1) sat_d = 1'b1;
            else count_d = count_q + CW'(1);
          end else begin
            row_d  = row_q + LN'(1);
            cand_d = '0;
          end
        end else begin
          cand_d = cand_q + LN'(1);
        end
      end
      S_EMIT: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.sol_ready) begin
          if (mode_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SEARCH;
            cand_d  = last_col + LN'(1);
            colm_d  = colm_q & ~uc_bit;
            dgm_d   = dgm_q & ~ud_bit;
            adm_d   = adm_q & ~ua_bit;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      cand_q  <= '0;
      place_q <= '0;
      sol_q   <= '0;
      colm_q  <= '0;
      dgm_q   <= '0;
      adm_q   <= '0;
      mode_q  <= 1'b0;
      found_q <= 1'b0;
      sat_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cand_q  <= cand_d;
      place_q <= place_d;
      sol_q   <= sol_d;
      colm_q  <= colm_d;
      dgm_q   <= dgm_d;
      adm_q   <= adm_d;
      mode_q  <= mode_d;
      found_q <= found_d;
      sat_q   <= sat_d;
      count_q <= count_d;
    end
  end

  assign bus.busy      = (state_q == S_SEARCH) || (state_q == S_EMIT);
  assign bus.done      = (state_q == S_DONE);
  assign bus.sol_valid = (state_q == S_EMIT);
  assign bus.found     = found_q;
  assign bus.sat       = sat_q;
  assign bus.count     = count_q;
  assign bus.sol_cols  = sol_q;
endmodule

// File: tb/tb_queen_solver.sv
// Directed bench for queen_solver over several board sizes and counter widths.
module tb_queen_solver;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  queen_solver_if #(.N(8), .LN(5), .CW(32)) if8 ();
  queen_solver_if #(.N(8), .LN(5), .CW(3))  ifs ();
  queen_solver_if #(.N(4), .LN(3), .CW(8))  if4 ();
  queen_solver_if #(.N(6), .LN(3), .CW(8))  if6 ();
  queen_solver_if #(.N(3), .LN(2), .CW(4))  if3 ();
  queen_solver_if #(.N(1), .LN(1), .CW(4))  if1 ();

  queen_solver #(.N(8), .LN(5), .CW(32)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  queen_solver #(.N(8), .LN(5), .CW(3))  duts (.clk(clk), .rst(rst), .bus(ifs));
  queen_solver #(.N(4), .LN(3), .CW(8))  dut4 (.clk(clk), .rst(rst), .bus(if4));
  queen_solver #(.N(6), .LN(3), .CW(8))  dut6 (.clk(clk), .rst(rst), .bus(if6));
  queen_solver #(.N(3), .LN(2), .CW(4))  dut3 (.clk(clk), .rst(rst), .bus(if3));
  queen_solver #(.N(1), .LN(1), .CW(4))  dut1 (.clk(clk), .rst(rst), .bus(if1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent 8x8 legality check: distinct columns, no shared diagonal.
  function automatic bit board_ok(input logic [39:0] s);
    int c[8];
    for (int i = 0; i < 8; i++) c[i] = int'(s[i*5 +: 5]);
    for (int i = 0; i < 8; i++) begin
      if (c[i] > 7) return 1'b0;
      for (int j = i + 1; j < 8; j++)
        if (c[i] == c[j] || c[i] - c[j] == j - i || c[j] - c[i] == j - i) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Row 0 is the most significant digit of the lexicographic key.
  function automatic int unsigned board_key(input logic [39:0] s);
    int unsigned k = 0;
    for (int i = 0; i < 8; i++) k = k * 8 + int'(s[i*5 +: 5] & 5'd7);
    return k;
  endfunction

  function automatic logic [39:0] first8();
    int e[8] = '{0, 4, 7, 5, 2, 6, 1, 3};
    logic [39:0] v = '0;
    for (int r = 0; r < 8; r++) v[r*5 +: 5] = 5'(e[r]);
    return v;
  endfunction

  task automatic init_inputs();
    {if8.start, if8.mode, if8.abort, if8.sol_ready} = 4'b0;
    {ifs.start, ifs.mode, ifs.abort, ifs.sol_ready} = 4'b0;
    {if4.start, if4.mode, if4.abort, if4.sol_ready} = 4'b0;
    {if6.start, if6.mode, if6.abort, if6.sol_ready} = 4'b0;
    {if3.start, if3.mode, if3.abort, if3.sol_ready} = 4'b0;
    {if1.start, if1.mode, if1.abort, if1.sol_ready} = 4'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({if8.busy, if8.done, if8.found, if8.sat, if8.sol_valid} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b, expected 00000",
               {if8.busy, if8.done, if8.found, if8.sat, if8.sol_valid});
    end
    n_cmp++;
    if (if8.count !== 32'd0 || if8.sol_cols !== 40'd0) begin
      n_bad++;
      $display("FAIL reset_data: count %0d cols %h, expected 0 and 0", if8.count, if8.sol_cols);
    end
    #2 rst = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (if8.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_no_start: busy %b, expected 0", if8.busy);
    end
  endtask

  task automatic test_count_all_n8();
    int unsigned hs = 0, cyc = 0, dones = 0, prev_key = 0, bad_board = 0, bad_order = 0;
    logic [39:0] exp_first;
    exp_first = first8();
    if8.mode = 1'b0;
    if8.sol_ready = 1'b1;
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    n_cmp++;
    if (if8.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL n8_busy_after_start: got %b, expected 1", if8.busy);
    end
    while (if8.done !== 1'b1 && cyc < 40000) begin
      if (if8.sol_valid === 1'b1) begin
        hs++;
        if (!board_ok(if8.sol_cols)) bad_board++;
        if (hs > 1 && board_key(if8.sol_cols) <= prev_key) bad_order++;
        prev_key = board_key(if8.sol_cols);
        if (hs == 1) begin
          n_cmp++;
          if (if8.sol_cols !== exp_first) begin
            n_bad++;
            $display("FAIL n8_first_solution: got %h, expected %h", if8.sol_cols, exp_first);
          end
        end
      end
      tick();
      cyc++;
    end
    if (if8.done === 1'b1) dones = 1;
    n_cmp++;
    if (if8.busy !== 1'b0 || if8.count !== 32'd92 || if8.found !== 1'b1 || if8.sat !== 1'b0) begin
      n_bad++;
      $display("FAIL n8_final: busy %b count %0d found %b sat %b, expected 0 92 1 0",
               if8.busy, if8.count, if8.found, if8.sat);
    end
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      if (if8.done === 1'b1) dones++;
    end
    n_cmp++;
    if (hs !== 92) begin
      n_bad++;
      $display("FAIL n8_handshakes: got %0d, expected 92", hs);
    end
    n_cmp++;
    if (dones !== 1) begin
      n_bad++;
      $display("FAIL n8_done_pulses: got %0d, expected 1", dones);
    end
    n_cmp++;
    if (bad_board !== 0 || bad_order !== 0) begin
      n_bad++;
      $display("FAIL n8_solution_set: illegal %0d out-of-order %0d, expected 0 0", bad_board, bad_order);
    end
  endtask

  task automatic test_saturation();
    int unsigned hs = 0, cyc = 0;
    int unsigned exp_cnt;
    ifs.mode = 1'b0;
    ifs.sol_ready = 1'b1;
    ifs.start = 1'b1;
    tick();
    ifs.start = 1'b0;
    while (ifs.done !== 1'b1 && cyc < 40000) begin
      if (ifs.sol_valid === 1'b1) begin
        hs++;
        exp_cnt = (hs < 7) ? hs : 7;
        n_cmp++;
        if (ifs.count !== 3'(exp_cnt) || ifs.sat !== (hs >= 8)) begin
          n_bad++;
          $display("FAIL sat_progress #%0d: count %0d sat %b, expected %0d %b",
                   hs, ifs.count, ifs.sat, exp_cnt, (hs >= 8));
        end
      end
      tick();
      cyc++;
    end
    n_cmp++;
    if (ifs.done !== 1'b1 || hs !== 92 || ifs.count !== 3'd7 || ifs.sat !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_final: done %b hs %0d count %0d sat %b, expected 1 92 7 1",
               ifs.done, hs, ifs.count, ifs.sat);
    end
  endtask

  task automatic test_stall_n4();
    logic [11:0] expv [2];
    logic [11:0] held_val = '0;
    bit held = 1'b0;
    int unsigned hs = 0, cyc = 0, stalls = 0;
    int ea[4] = '{1, 3, 0, 2};
    int eb[4] = '{2, 0, 3, 1};
    for (int r = 0; r < 4; r++) begin
      expv[0][r*3 +: 3] = 3'(ea[r]);
      expv[1][r*3 +: 3] = 3'(eb[r]);
    end
    if4.mode = 1'b0;
    if4.sol_ready = 1'b0;
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    while (if4.done !== 1'b1 && cyc < 2000) begin
      if (if4.sol_valid === 1'b1) begin
        if (held) begin
          stalls++;
          n_cmp++;
          if (if4.sol_cols !== held_val) begin
            n_bad++;
            $display("FAIL n4_stable: got %h, expected %h", if4.sol_cols, held_val);
          end
          if4.sol_ready = 1'($urandom_range(0, 1));
        end else begin
          held = 1'b1;
          held_val = if4.sol_cols;
          n_cmp++;
          if (hs >= 2) begin
            n_bad++;
            $display("FAIL n4_extra_solution: got solution %0d, expected 2 total", hs + 1);
          end else if (if4.sol_cols !== expv[hs]) begin
            n_bad++;
            $display("FAIL n4_solution #%0d: got %h, expected %h", hs, if4.sol_cols, expv[hs]);
          end
          if4.sol_ready = 1'b0;
        end
        if (if4.sol_ready) begin
          hs++;
          held = 1'b0;
        end
      end else begin
        if4.sol_ready = 1'($urandom_range(0, 1));
      end
      tick();
      cyc++;
    end
    n_cmp++;
    if (if4.done !== 1'b1 || hs !== 2 || if4.count !== 8'd2 || if4.found !== 1'b1) begin
      n_bad++;
      $display("FAIL n4_final: done %b hs %0d count %0d found %b, expected 1 2 2 1",
               if4.done, hs, if4.count, if4.found);
    end
    n_cmp++;
    if (stalls < 2) begin
      n_bad++;
      $display("FAIL n4_stall_cycles: got %0d, expected at least 2", stalls);
    end
  endtask

  task automatic test_first_only_n6();
    int e[6] = '{1, 3, 5, 0, 2, 4};
    logic [17:0] expv = '0;
    int unsigned hs = 0, cyc = 0, extra = 0;
    for (int r = 0; r < 6; r++) expv[r*3 +: 3] = 3'(e[r]);
    if6.mode = 1'b1;
    if6.sol_ready = 1'b1;
    if6.start = 1'b1;
    tick();
    if6.start = 1'b0;
    while (if6.done !== 1'b1 && cyc < 5000) begin
      if (if6.sol_valid === 1'b1) begin
        hs++;
        n_cmp++;
        if (if6.sol_cols !== expv) begin
          n_bad++;
          $display("FAIL n6_solution: got %h, expected %h", if6.sol_cols, expv);
        end
      end
      tick();
      cyc++;
    end
    n_cmp++;
    if (if6.done !== 1'b1 || hs !== 1 || if6.count !== 8'd1 || if6.found !== 1'b1) begin
      n_bad++;
      $display("FAIL n6_final: done %b hs %0d count %0d found %b, expected 1 1 1 1",
               if6.done, hs, if6.count, if6.found);
    end
    for (int unsigned i = 0; i < 20; i++) begin
      tick();
      if (if6.sol_valid === 1'b1 || if6.done === 1'b1) extra++;
    end
    n_cmp++;
    if (extra !== 0 || if6.sol_cols !== expv) begin
      n_bad++;
      $display("FAIL n6_after_done: extra %0d cols %h, expected 0 %h", extra, if6.sol_cols, expv);
    end
  endtask

  task automatic test_small_boards();
    int unsigned hs3 = 0, hs1 = 0, cyc = 0;
    if3.sol_ready = 1'b1;
    if1.sol_ready = 1'b1;
    if3.start = 1'b1;
    if1.start = 1'b1;
    tick();
    if3.start = 1'b0;
    if1.start = 1'b0;
    while (if3.done !== 1'b1 && cyc < 500) begin
      if (if3.sol_valid === 1'b1) hs3++;
      tick();
      cyc++;
    end
    n_cmp++;
    if (if3.done !== 1'b1 || hs3 !== 0 || if3.count !== 4'd0 || if3.found !== 1'b0) begin
      n_bad++;
      $display("FAIL n3_final: done %b hs %0d count %0d found %b, expected 1 0 0 0",
               if3.done, hs3, if3.count, if3.found);
    end
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    cyc = 0;
    while (if1.done !== 1'b1 && cyc < 100) begin
      if (if1.sol_valid === 1'b1) hs1++;
      tick();
      cyc++;
    end
    n_cmp++;
    if (if1.done !== 1'b1 || hs1 !== 1 || if1.count !== 4'd1 || if1.found !== 1'b1 ||
        if1.sol_cols !== 1'b0) begin
      n_bad++;
      $display("FAIL n1_final: done %b hs %0d count %0d found %b cols %b, expected 1 1 1 1 0",
               if1.done, hs1, if1.count, if1.found, if1.sol_cols);
    end
  endtask

  task automatic test_abort();
    int unsigned dones = 0, changes = 0, cyc = 0;
    logic [31:0] snap;
    if8.mode = 1'b0;
    if8.sol_ready = 1'b1;
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    for (int unsigned i = 0; i < 49; i++) tick();
    if8.abort = 1'b1;
    tick();
    if8.abort = 1'b0;
    n_cmp++;
    if (if8.busy !== 1'b0 || if8.sol_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_busy: busy %b valid %b, expected 0 0", if8.busy, if8.sol_valid);
    end
    snap = if8.count;
    for (int unsigned i = 0; i < 30; i++) begin
      if (if8.done === 1'b1) dones++;
      if (if8.count !== snap) changes++;
      tick();
    end
    n_cmp++;
    if (dones !== 0 || changes !== 0) begin
      n_bad++;
      $display("FAIL abort_quiet: done pulses %0d count changes %0d, expected 0 0", dones, changes);
    end
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    while (if8.sol_valid !== 1'b1 && cyc < 40000) begin
      tick();
      cyc++;
    end
    if8.abort = 1'b1;
    tick();
    if8.abort = 1'b0;
    dones = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (if8.done === 1'b1 || if8.sol_valid === 1'b1) dones++;
      tick();
    end
    n_cmp++;
    if (if8.busy !== 1'b0 || if8.count !== 32'd1 || if8.found !== 1'b1 || dones !== 0) begin
      n_bad++;
      $display("FAIL abort_vs_handshake: busy %b count %0d found %b pulses %0d, expected 0 1 1 0",
               if8.busy, if8.count, if8.found, dones);
    end
  endtask

  task automatic test_busy_start_and_reset();
    int unsigned hs = 0, cyc = 0;
    if8.mode = 1'b0;
    if8.sol_ready = 1'b0;
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    while (if8.sol_valid !== 1'b1 && cyc < 40000) begin
      tick();
      cyc++;
    end
    tick();
    tick();
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    n_cmp++;
    if (if8.sol_valid !== 1'b1 || if8.count !== 32'd1 || if8.sol_cols !== first8()) begin
      n_bad++;
      $display("FAIL start_in_emit: valid %b count %0d cols %h, expected 1 1 %h",
               if8.sol_valid, if8.count, if8.sol_cols, first8());
    end
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({if8.busy, if8.done, if8.found, if8.sat, if8.sol_valid} !== 5'b0 ||
        if8.count !== 32'd0 || if8.sol_cols !== 40'd0) begin
      n_bad++;
      $display("FAIL reset_mid_emit: flags %b count %0d cols %h, expected 00000 0 0",
               {if8.busy, if8.done, if8.found, if8.sat, if8.sol_valid}, if8.count, if8.sol_cols);
    end
    rst = 1'b0;
    tick();
    if8.sol_ready = 1'b1;
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    cyc = 0;
    while (if8.done !== 1'b1 && cyc < 40000) begin
      if (if8.sol_valid === 1'b1) hs++;
      if (cyc == 3000) if8.start = 1'b1;
      else if8.start = 1'b0;
      tick();
      cyc++;
    end
    if8.start = 1'b0;
    n_cmp++;
    if (if8.done !== 1'b1 || hs !== 92 || if8.count !== 32'd92) begin
      n_bad++;
      $display("FAIL restart_after_reset: done %b hs %0d count %0d, expected 1 92 92",
               if8.done, hs, if8.count);
    end
  endtask

  initial begin
    init_inputs();
    test_reset();
    fork
      test_count_all_n8();
      test_saturation();
    join
    test_stall_n4();
    test_first_only_n6();
    test_small_boards();
    test_abort();
    test_busy_start_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
